kp_scanner: RTL and testbench
=============================

KP_SCANNER -- requirements
Module: kp_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clocks per column step while scanning; legal values are 2 or more.
REQ-002 Parameter DB_CNT, default 20000: consecutive stable clocks needed for press and release debounce; legal values are 2 or more.
REQ-003 clk  input  1  system clock; one clock domain; all state on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 row  input  4  keypad rows; active-low; pulled up externally; asynchronous to clk.
REQ-006 col  output  4  keypad column drive; active-low one-hot.
REQ-007 key  output  4  debounced key code.
REQ-008 ena  output  1  key-valid strobe; high while a debounced key is held; feeds KP_Latch.ena.

Function
REQ-009 row SHALL pass through a 2-flop synchronizer (rs); all FSM decisions use rs only.
REQ-010 FSM states SHALL be SCAN, PRESS_DB, HELD, REL_DB.
REQ-011 SCAN: col steps 1110 -> 1101 -> 1011 -> 0111 -> 1110; it advances once every SCAN_DIV clocks and wraps around.
REQ-012 SCAN: on the last clock of a column period with rs != 1111, the block captures rs and the column index, freezes col, clears the debounce counter, and enters PRESS_DB.
REQ-013 SCAN: if more than one row bit is low, the lowest-index low row is chosen.
REQ-014 PRESS_DB: rs must equal the captured pattern for DB_CNT consecutive clocks.
REQ-015 PRESS_DB: any mismatch returns to SCAN; col advances to the next column and the divider restarts.
REQ-016 PRESS_DB -> HELD: key is loaded with the code and ena goes to 1 on the same clock edge.
REQ-017 HELD: ena stays 1 and col stays frozen. If rs == 1111, the counter clears and the FSM enters REL_DB.
REQ-018 REL_DB: needs DB_CNT consecutive clocks of rs == 1111, then ena goes to 0, the FSM enters SCAN, and scanning resumes at the next column.
REQ-019 REL_DB: any rs != 1111 returns to HELD; ena stays 1 with no glitch and key is unchanged.
REQ-020 key SHALL change only on PRESS_DB -> HELD. key is stable while ena = 1 and held after ena falls until the next debounced press, so a latch clocked on the falling edge of ena captures the correct code.
REQ-021 ena SHALL have exactly one rising and one falling edge per debounced keypress.
REQ-022 Latency: a clean press in the active column raises ena 2 (sync) + DB_CNT clocks after row changes, +/-1 clock.
REQ-023 Raw code SHALL be {row_idx[1:0], col_idx[1:0]}, where the index is the bit position of the low signal.
REQ-024 Divider and debounce counters SHALL be sized by $clog2 of their parameter and SHALL saturate or clear; they SHALL never wrap mid-count.

Reset
REQ-025 While rst_n = 0: state = SCAN, col = 1110, key = 0000, ena = 0, synchronizer = 1111, counters = 0.
REQ-026 Reset asserted in any state, including mid-debounce or HELD, SHALL force the REQ-025 values immediately and asynchronously.
REQ-027 Deassertion SHALL be synchronized to clk (2-flop).
REQ-028 Scanning SHALL start on the first clock after synchronized release, with no spurious ena pulse.

Configuration
REQ-029 Macro KP_HEX_MAP_EN. When defined, key SHALL use the standard 4x4 hex keypad legend, indexed [row][col]:
 - row 0: 1, 2, 3, A
 - row 1: 4, 5, 6, B
 - row 2: 7, 8, 9, C
 - row 3: E(*), 0, F(#), D
REQ-030 When KP_HEX_MAP_EN is undefined, key SHALL be the raw code of REQ-023. Timing and FSM behaviour SHALL be identical in both builds.

Verification (SCAN_DIV = 4, DB_CNT = 8)
REQ-031 Reset: rst_n = 0 at any time -> col = 1110, key = 0, ena = 0 within the same clock; after release, col steps every 4 clocks 1110, 1101, 1011, 0111, 1110.
REQ-032 Clean press: row1 held low while col = 1011 -> ena rises about 10 clocks later, col stays 1011, and key = 0110 raw / 6 with KP_HEX_MAP_EN.
REQ-033 Press bounce: row0 low for 3 clocks then high in col 0 -> ena stays 0 and scanning resumes at col = 1101.
REQ-034 Release bounce: while held, release for 5 clocks, press again, then release -> ena stays 1 until 8 clean high clocks, then falls once; key is unchanged and holds after the fall.
REQ-035 Multi-key: rows 0 and 2 low together in col 3 -> key = 0011 raw / A hex.
REQ-036 Reset in HELD: assert rst_n = 0 while ena = 1 -> ena = 0 and key = 0 asynchronously; after release, no ena pulse while row = 1111.

Source files
------------

// File: rtl/kp_scanner.sv
// 4x4 keypad scanner: column scan, row synchronizer, press/release debounce, key-valid strobe.
// Optional build macro KP_HEX_MAP_EN maps {row,col} to the hex keypad legend instead of the raw code.
module kp_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DB_CNT   = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       ena
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DB_CNT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CNT - 1);

  typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

  state_t           state_q, state_d;
  logic [1:0]       rst_sync_q;
  logic             arst_n;
  logic [3:0]       rs_meta_q, rs_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DB_W-1:0]  db_q, db_d;
  logic [3:0]       col_q, col_d;
  logic [3:0]       cap_q, cap_d;
  logic [1:0]       caprow_q, caprow_d;
  logic [3:0]       key_q, key_d;
  logic             ena_q, ena_d;

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    if (!v[0])      return 2'd0;
    else if (!v[1]) return 2'd1;
    else if (!v[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  function automatic logic [3:0] rot_col(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

`ifdef KP_HEX_MAP_EN
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'h1;
      4'h1: return 4'h2;
      4'h2: return 4'h3;
      4'h3: return 4'hA;
      4'h4: return 4'h4;
      4'h5: return 4'h5;
      4'h6: return 4'h6;
      4'h7: return 4'hB;
      4'h8: return 4'h7;
      4'h9: return 4'h8;
      4'hA: return 4'h9;
      4'hB: return 4'hC;
      4'hC: return 4'hE;
      4'hD: return 4'h0;
      4'hE: return 4'hF;
      default: return 4'hD;
    endcase
  endfunction
`else
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    return {r, c};
  endfunction
`endif

  // Reset asserts asynchronously but releases two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign arst_n = rst_sync_q[1];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= SCAN;
      rs_meta_q <= 4'hF;
      rs_q      <= 4'hF;
      div_q     <= '0;
      db_q      <= '0;
      col_q     <= 4'b1110;
      cap_q     <= 4'hF;
      caprow_q  <= 2'd0;
      key_q     <= 4'h0;
      ena_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rs_meta_q <= row;
      rs_q      <= rs_meta_q;
      div_q     <= div_d;
      db_q      <= db_d;
      col_q     <= col_d;
      cap_q     <= cap_d;
      caprow_q  <= caprow_d;
      key_q     <= key_d;
      ena_q     <= ena_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:     if (div_q == DIV_LAST && rs_q != 4'hF) state_d = PRESS_DB;
      PRESS_DB: if (rs_q != cap_q)                     state_d = SCAN;
                else if (db_q == DB_LAST)              state_d = HELD;
      HELD:     if (rs_q == 4'hF)                      state_d = REL_DB;
      REL_DB:   if (rs_q != 4'hF)                      state_d = HELD;
                else if (db_q == DB_LAST)              state_d = SCAN;
      default:                                         state_d = SCAN;
    endcase
  end

  // Counters clear on every entry and stop at their terminal value, so they never wrap.
  always_comb begin
    div_d    = div_q;
    db_d     = db_q;
    col_d    = col_q;
    cap_d    = cap_q;
    caprow_d = caprow_q;
    key_d    = key_q;
    ena_d    = ena_q;
    case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (rs_q != 4'hF) begin
            cap_d    = rs_q;
            caprow_d = low_idx(rs_q);
            db_d     = '0;
          end else begin
            col_d = rot_col(col_q);
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      PRESS_DB: begin
        if (rs_q != cap_q) begin
          col_d = rot_col(col_q);
          div_d = '0;
        end else if (db_q == DB_LAST) begin
          key_d = key_code(caprow_q, low_idx(col_q));
          ena_d = 1'b1;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      HELD: begin
        if (rs_q == 4'hF) db_d = '0;
      end
      REL_DB: begin
        if (rs_q == 4'hF) begin
          if (db_q == DB_LAST) begin
            ena_d = 1'b0;
            col_d = rot_col(col_q);
            div_d = '0;
          end else begin
            db_d = db_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign col = col_q;
  assign key = key_q;
  assign ena = ena_q;

endmodule

// File: tb/tb_kp_scanner.sv
// Bench for kp_scanner: behavioural run-length model checked every cycle plus directed keypad scenarios.
module tb_kp_scanner;
  localparam int SCAN_DIV = 4;
  localparam int DB_CNT   = 8;

`ifdef KP_HEX_MAP_EN
  localparam logic [3:0] EXP_R1C2 = 4'h6;
  localparam logic [3:0] EXP_R2C1 = 4'h8;
  localparam logic [3:0] EXP_R0C3 = 4'hA;
  localparam logic [3:0] EXP_R3C0 = 4'hE;
`else
  localparam logic [3:0] EXP_R1C2 = 4'h6;
  localparam logic [3:0] EXP_R2C1 = 4'h9;
  localparam logic [3:0] EXP_R0C3 = 4'h3;
  localparam logic [3:0] EXP_R3C0 = 4'hC;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row = 4'hF;
  logic [3:0] col, key;
  logic       ena;

  int tests = 0;
  int fails = 0;

  kp_scanner #(.SCAN_DIV(SCAN_DIV), .DB_CNT(DB_CNT)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .key(key), .ena(ena)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Model: keypad behaviour expressed as column position, tick within the period and run lengths.
  bit [3:0] hex_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  int       m_rel, m_tick, m_col, m_run, m_row;
  bit       m_locked, m_ena;
  bit [3:0] m_rs1, m_rs2, m_cap, m_key;

  function automatic bit [3:0] model_code(input int r, input int c);
`ifdef KP_HEX_MAP_EN
    return hex_tab[r*4 + c];
`else
    return 4'(r*4 + c);
`endif
  endfunction

  always @(posedge clk) begin
    bit [3:0] rs;
    if (!rst_n) begin
      m_rel = 0; m_tick = 0; m_col = 0; m_run = 0; m_row = 0;
      m_locked = 0; m_ena = 0; m_rs1 = 4'hF; m_rs2 = 4'hF; m_cap = 4'hF; m_key = 0;
    end else if (m_rel < 2) begin
      m_rel++;
    end else begin
      rs = m_rs2;
      if (!m_locked) begin
        if (m_tick == SCAN_DIV - 1) begin
          m_tick = 0;
          if (rs != 4'hF) begin
            m_locked = 1; m_cap = rs; m_run = 1;
            for (int i = 3; i >= 0; i--) if (!rs[i]) m_row = i;
          end else m_col = (m_col + 1) % 4;
        end else m_tick++;
      end else if (!m_ena) begin
        if (rs != m_cap) begin
          m_locked = 0; m_col = (m_col + 1) % 4; m_tick = 0;
        end else begin
          m_run++;
          if (m_run == DB_CNT + 1) begin
            m_ena = 1; m_key = model_code(m_row, m_col); m_run = 0;
          end
        end
      end else begin
        m_run = (rs == 4'hF) ? m_run + 1 : 0;
        if (m_run == DB_CNT + 1) begin
          m_ena = 0; m_locked = 0; m_col = (m_col + 1) % 4; m_tick = 0;
        end
      end
      m_rs2 = m_rs1;
      m_rs1 = row;
    end
    #1;
    check("model_col", col, ~(4'b0001 << m_col) & 4'hF);
    check("model_key", key, m_key);
    check("model_ena", ena, m_ena);
  end

  task automatic wait_col(input logic [3:0] c);
    logic [3:0] prev = col;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (col == c && prev != c) return;
      prev = col;
    end
    check("wait_col_timeout", col, c);
  endtask

  task automatic wait_ena(input logic v, output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (ena == v) return;
    end
    check("wait_ena_timeout", ena, v);
  endtask

  initial begin
    logic [3:0] seq[$];
    logic [3:0] prev;
    int n;
    bit seen;

    // Reset values and column stepping after release.
    repeat (3) @(negedge clk);
    check("rst_col", col, 4'b1110);
    check("rst_key", key, 4'h0);
    check("rst_ena", ena, 1'b0);
    rst_n = 1'b1;
    prev = col;
    seq.push_back(col);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (col != prev) seq.push_back(col);
      prev = col;
    end
    check("seq0", seq[0], 4'b1110);
    check("seq1", seq[1], 4'b1101);
    check("seq2", seq[2], 4'b1011);
    check("seq3", seq[3], 4'b0111);
    check("seq4", seq[4], 4'b1110);

    // Clean press of row 1 in column 2.
    wait_col(4'b1011);
    row = 4'b1101;
    wait_ena(1'b1, n);
    check("press_latency_ok", (n >= 9 && n <= 14), 1);
    check("press_col_frozen", col, 4'b1011);
    check("press_key", key, EXP_R1C2);
    row = 4'hF;
    wait_ena(1'b0, n);
    check("release_key_held", key, EXP_R1C2);
    check("release_next_col", col, 4'b0111);

    // Press bounce in column 0.
    wait_col(4'b1110);
    row = 4'b1110;
    repeat (3) @(negedge clk);
    row = 4'hF;
    seen = 0;
    repeat (3) begin @(negedge clk); if (ena) seen = 1; end
    check("bounce_next_col", col, 4'b1101);
    repeat (10) begin @(negedge clk); if (ena) seen = 1; end
    check("bounce_no_ena", seen, 0);

    // Release bounce: row 2 in column 1.
    wait_col(4'b1101);
    row = 4'b1011;
    wait_ena(1'b1, n);
    check("rb_key", key, EXP_R2C1);
    seen = 0;
    row = 4'hF;
    repeat (5) begin @(negedge clk); if (!ena) seen = 1; end
    row = 4'b1011;
    repeat (2) begin @(negedge clk); if (!ena) seen = 1; end
    row = 4'hF;
    check("rb_ena_steady", seen, 0);
    wait_ena(1'b0, n);
    check("rb_fall_delay_ok", (n >= DB_CNT + 1), 1);
    seen = 0;
    repeat (20) begin @(negedge clk); if (ena) seen = 1; end
    check("rb_single_fall", seen, 0);
    check("rb_key_after", key, EXP_R2C1);

    // Two rows low together in column 3: lowest row wins.
    wait_col(4'b0111);
    row = 4'b1010;
    wait_ena(1'b1, n);
    check("multi_key", key, EXP_R0C3);
    row = 4'hF;
    wait_ena(1'b0, n);

    // Asynchronous reset while a key is held.
    wait_col(4'b1110);
    row = 4'b0111;
    wait_ena(1'b1, n);
    check("held_key", key, EXP_R3C0);
    rst_n = 1'b0;
    #1;
    check("async_ena", ena, 1'b0);
    check("async_key", key, 4'h0);
    check("async_col", col, 4'b1110);
    row = 4'hF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (ena) seen = 1; end
    check("post_rst_no_ena", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
